// File: rtl/dat_write_ctrl.sv
// SD DAT0 single-bit write-block sequencer: frames start bit, data bytes, CRC16 and end bit,
// then parses the card's CRC status token and waits out card busy.
module dat_write_ctrl #(
    parameter int unsigned STATUS_TIMEOUT = 16,
    parameter int unsigned BUSY_CNT_W     = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [11:0] block_len_i,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic        dat_o,
    output logic        dat_oe_o,
    input  logic        dat_i,
    output logic        crc_dat_o,
    output logic        crc_shift_o,
    input  logic        crc_ser_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  status_o,
    output logic        crc_err_o,
    output logic        timeout_err_o,
    output logic        underrun_err_o
);
    // state       | meaning
    // IDLE        | line released, CRC engine idle at zero
    // START       | drive start bit, load first byte
    // DATA        | shift bytes out MSB first into line and CRC engine
    // CRC         | drive 16 CRC bits from the engine
    // END         | drive end bit
    // STATUS_WAIT | line released, wait for token start bit
    // STATUS      | capture 3 status bits and the token end bit
    // BUSY        | wait for card to release DAT0
    // DONE        | one-cycle completion pulse
    // FLUSH       | abort: 16 shift-out cycles return the CRC engine to zero
    typedef enum logic [3:0] {
        IDLE, START, DATA, CRC, END, STATUS_WAIT, STATUS, BUSY, DONE, FLUSH
    } state_t;

    localparam int unsigned TW = (STATUS_TIMEOUT > 1) ? $clog2(STATUS_TIMEOUT) : 1;

    state_t                  state_q, state_d;
    logic [7:0]              sr_q, sr_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [11:0]             byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic [BUSY_CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic [2:0]              status_q, status_d;
    logic                    crc_err_q, crc_err_d;
    logic                    tmo_err_q, tmo_err_d;
    logic                    urun_err_q, urun_err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            busy_cnt_q <= '0;
            status_q   <= '0;
            crc_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
            urun_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            busy_cnt_q <= busy_cnt_d;
            status_q   <= status_d;
            crc_err_q  <= crc_err_d;
            tmo_err_q  <= tmo_err_d;
            urun_err_q <= urun_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        busy_cnt_d   = busy_cnt_q;
        status_d     = status_q;
        crc_err_d    = crc_err_q;
        tmo_err_d    = tmo_err_q;
        urun_err_d   = urun_err_q;
        dat_o        = 1'b1;
        dat_oe_o     = 1'b0;
        crc_dat_o    = 1'b0;
        crc_shift_o  = 1'b0;
        data_ready_o = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = START;
                    byte_cnt_d = (block_len_i == 12'd0) ? 12'd0 : block_len_i - 12'd1;
                    crc_err_d  = 1'b0;
                    tmo_err_d  = 1'b0;
                    urun_err_d = 1'b0;
                end
            end
            START: begin
                dat_o        = 1'b0;
                dat_oe_o     = 1'b1;
                data_ready_o = 1'b1;
                sr_d         = data_valid_i ? data_i : 8'h00;
                if (!data_valid_i) urun_err_d = 1'b1;
                bit_cnt_d    = 4'd7;
                state_d      = DATA;
            end
            DATA: begin
                dat_o     = sr_q[7];
                crc_dat_o = sr_q[7];
                dat_oe_o  = 1'b1;
                sr_d      = {sr_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    if (byte_cnt_q != 12'd0) begin
                        // Underrun sends 0x00; the CRC engine sees the same zeros.
                        data_ready_o = 1'b1;
                        sr_d         = data_valid_i ? data_i : 8'h00;
                        if (!data_valid_i) urun_err_d = 1'b1;
                        bit_cnt_d    = 4'd7;
                        byte_cnt_d   = byte_cnt_q - 12'd1;
                    end else begin
                        bit_cnt_d = 4'd15;
                        state_d   = CRC;
                    end
                end
            end
            CRC: begin
                crc_shift_o = 1'b1;
                dat_o       = crc_ser_i;
                dat_oe_o    = 1'b1;
                bit_cnt_d   = bit_cnt_q - 4'd1;
                if (bit_cnt_q == 4'd0) state_d = END;
            end
            END: begin
                dat_o     = 1'b1;
                dat_oe_o  = 1'b1;
                tmo_cnt_d = TW'(STATUS_TIMEOUT - 1);
                state_d   = STATUS_WAIT;
            end
            STATUS_WAIT: begin
                if (!dat_i) begin
                    bit_cnt_d = 4'd0;
                    state_d   = STATUS;
                end else if (tmo_cnt_q == '0) begin
                    tmo_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TW'(1);
                end
            end
            STATUS: begin
                if (bit_cnt_q != 4'd3) begin
                    status_d  = {status_q[1:0], dat_i};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else begin
                    if (status_q != 3'b010 || !dat_i) crc_err_d = 1'b1;
                    busy_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (dat_i && busy_cnt_q >= BUSY_CNT_W'(2)) begin
                    state_d = DONE;
                end else if (busy_cnt_q == {BUSY_CNT_W{1'b1}}) begin
                    tmo_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    busy_cnt_d = busy_cnt_q + BUSY_CNT_W'(1);
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            FLUSH: begin
                crc_shift_o = 1'b1;
                bit_cnt_d   = bit_cnt_q - 4'd1;
                if (bit_cnt_q == 4'd0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over every other transition and leaves the sticky flags as they were.
        if (abort_i && state_q != IDLE && state_q != FLUSH) begin
            state_d    = FLUSH;
            bit_cnt_d  = 4'd15;
            status_d   = status_q;
            crc_err_d  = crc_err_q;
            tmo_err_d  = tmo_err_q;
            urun_err_d = urun_err_q;
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign status_o       = status_q;
    assign crc_err_o      = crc_err_q;
    assign timeout_err_o  = tmo_err_q;
    assign underrun_err_o = urun_err_q;

endmodule
